// File: rtl/int_dispatch.sv
// int_dispatch: CPU-side interrupt entry sequencer.
// At an instruction boundary it accepts the controller's pending interrupt and
// stalls the core. For normal IDs it pushes PC (high byte first) and FLAGS to the
// stack. It then reads the 16-bit vector, strobes the new PC into the core,
// pulses ACK to the controller, and waits for the request to clear before it
// re-arms. The reset ID skips the context save and ignores the global enable.
module int_dispatch #(
  parameter int              ADDR_W      = 16,
  parameter logic [ADDR_W-1:0] VEC_BASE  = 16'hFFE0,
  parameter logic [3:0]      INT_ID_RSTB = 4'b1000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        next_id,
  input  logic              next_on,
  input  logic              rstb,
  output logic              ack,
  input  logic              ie,
  input  logic              insn_end,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic [7:0]        flags_in,
  output logic              hold,
  output logic              stk_req,
  output logic [7:0]        stk_data,
  input  logic              stk_rdy,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  input  logic              mem_rdy,
  output logic              pc_load,
  output logic [ADDR_W-1:0] pc_out,
  output logic [3:0]        active_id
);

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_PUSH_PCH = 4'd1;
  localparam logic [3:0] S_PUSH_PCL = 4'd2;
  localparam logic [3:0] S_PUSH_FLG = 4'd3;
  localparam logic [3:0] S_VEC_LO   = 4'd4;
  localparam logic [3:0] S_VEC_HI   = 4'd5;
  localparam logic [3:0] S_LOAD     = 4'd6;
  localparam logic [3:0] S_ACK      = 4'd7;
  localparam logic [3:0] S_WAIT_CLR = 4'd8;

  logic [3:0]        state_reg;
  logic [3:0]        state_next;
  logic [3:0]        id_reg;
  logic [ADDR_W-1:0] pc_reg;
  logic [7:0]        flags_reg;
  logic [7:0]        vec_lo_reg;
  logic [ADDR_W-1:0] pc_out_reg;

  logic              is_rst_id;
  logic              entry;
  logic [ADDR_W-1:0] vec_off;
  logic [ADDR_W-1:0] vec_lo_addr;
  logic [ADDR_W-1:0] vec_hi_addr;

  // The reset ID bypasses the global enable so the core can always be re-vectored.
  assign is_rst_id = (next_id == INT_ID_RSTB);
  assign entry     = next_on & rstb & insn_end & (ie | is_rst_id);

  // Vector table entry n is two bytes at VEC_BASE + 2n; sums wrap at the address width.
  assign vec_off     = ADDR_W'({id_reg, 1'b0});
  assign vec_lo_addr = VEC_BASE + vec_off;
  assign vec_hi_addr = vec_lo_addr + ADDR_W'(1);

  // Next-state selection; a dropped RSTB aborts any in-flight sequence.
  always_comb begin
    state_next = state_reg;
    if ((state_reg != S_IDLE) && !rstb) begin
      state_next = S_IDLE;
    end else begin
      case (state_reg)
        S_IDLE:     if (entry) state_next = is_rst_id ? S_VEC_LO : S_PUSH_PCH;
        S_PUSH_PCH: if (stk_rdy) state_next = S_PUSH_PCL;
        S_PUSH_PCL: if (stk_rdy) state_next = S_PUSH_FLG;
        S_PUSH_FLG: if (stk_rdy) state_next = S_VEC_LO;
        S_VEC_LO:   if (mem_rdy) state_next = S_VEC_HI;
        S_VEC_HI:   if (mem_rdy) state_next = S_LOAD;
        S_LOAD:     state_next = S_ACK;
        S_ACK:      state_next = S_WAIT_CLR;
        S_WAIT_CLR: if (!next_on) state_next = S_IDLE;
        default:    state_next = S_IDLE;
      endcase
    end
  end

  // Handshake outputs decode from the state register so they hold steady while stalled.
  always_comb begin
    stk_req  = 1'b0;
    stk_data = 8'h00;
    mem_req  = 1'b0;
    mem_addr = '0;
    case (state_reg)
      S_PUSH_PCH: begin stk_req = 1'b1; stk_data = pc_reg[ADDR_W-1:8]; end
      S_PUSH_PCL: begin stk_req = 1'b1; stk_data = pc_reg[7:0];        end
      S_PUSH_FLG: begin stk_req = 1'b1; stk_data = flags_reg;          end
      S_VEC_LO:   begin mem_req = 1'b1; mem_addr = vec_lo_addr;        end
      S_VEC_HI:   begin mem_req = 1'b1; mem_addr = vec_hi_addr;        end
      default:    ;
    endcase
  end

  assign pc_load   = (state_reg == S_LOAD);
  assign ack       = (state_reg == S_ACK);
  assign hold      = (state_reg != S_IDLE) && (state_reg != S_WAIT_CLR);
  assign pc_out    = pc_out_reg;
  assign active_id = id_reg;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Context capture on entry; vector bytes captured only on completed reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_reg     <= 4'h0;
      pc_reg     <= '0;
      flags_reg  <= 8'h00;
      vec_lo_reg <= 8'h00;
      pc_out_reg <= '0;
    end else begin
      if ((state_reg == S_IDLE) && entry) begin
        id_reg    <= next_id;
        pc_reg    <= pc_in;
        flags_reg <= flags_in;
      end
      if ((state_reg == S_VEC_LO) && (state_next == S_VEC_HI)) begin
        vec_lo_reg <= mem_rdata;
      end
      if ((state_reg == S_VEC_HI) && (state_next == S_LOAD)) begin
        pc_out_reg <= {mem_rdata, vec_lo_reg};
      end
    end
  end

endmodule
